// File: rtl/flash_arb.sv
// rtl/flash_arb.sv - two-master QSPI flash read arbiter; optional response timeout via FLASH_ARB_TIMEOUT_EN
module flash_arb #(
   parameter int ADDR_W   = 24,
   parameter int LOCK_MAX = 8,
   parameter int TIMEOUT  = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic [ADDR_W-1:0] m0_addr,
   output logic [31:0]       m0_rdata,
   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic [ADDR_W-1:0] m1_addr,
   output logic [31:0]       m1_rdata,
   input  logic              m1_lock,
   output logic              s_valid,
   input  logic              s_ready,
   output logic [ADDR_W-1:0] s_addr,
   input  logic [31:0]       s_rdata,
   output logic [1:0]        grant,
   output logic              busy,
   output logic              err,
   input  logic              err_clr
);
   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DONE} state_t;

   state_t           state;
   logic             last_owner;   // 1 = m1 owned the previous transaction
   logic [CNT_W-1:0] lock_cnt;
   logic             pick_m1;
   logic             lock_hold;
   logic             req_any;
   logic             tmo;
   logic             done_now;
   logic [31:0]      resp_data;

   assign req_any = m0_valid | m1_valid;

   // Choose the next owner: single requester wins, ties alternate unless the loader burst lock holds m1
   always_comb begin
      lock_hold = m1_lock && last_owner && (lock_cnt < LOCK_LIM);
      if (m0_valid && m1_valid)
         pick_m1 = lock_hold ? 1'b1 : ~last_owner;
      else
         pick_m1 = m1_valid;
   end

`ifdef FLASH_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   logic [15:0] timer;

   // Timeout fires during the TIMEOUT-th busy cycle that has seen no response
   assign tmo = busy && !s_ready && (timer == TMO_LAST);

   // Count busy cycles waiting on the controller; restart for every transaction
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timer <= '0;
      else if (busy && !s_ready && !tmo)
         timer <= timer + 16'd1;
      else
         timer <= '0;
   end

   // Sticky timeout flag; a timeout beats a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         err <= 1'b0;
      else if (tmo)
         err <= 1'b1;
      else if (err_clr)
         err <= 1'b0;
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   assign done_now  = busy && (s_ready || tmo);
   assign resp_data = tmo ? 32'hFFFF_FFFF : s_rdata;
   assign m0_ready  = done_now && m0_valid && grant[0];
   assign m1_ready  = done_now && m1_valid && grant[1];
   assign m0_rdata  = grant[0] ? resp_data : 32'h0;
   assign m1_rdata  = grant[1] ? resp_data : 32'h0;

   // Transaction sequencer with registered downstream request, grant and busy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         s_valid    <= 1'b0;
         s_addr     <= '0;
         grant      <= 2'b00;
         busy       <= 1'b0;
         last_owner <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req_any) begin
                  state      <= pick_m1 ? BUSY1 : BUSY0;
                  s_valid    <= 1'b1;
                  s_addr     <= pick_m1 ? m1_addr : m0_addr;
                  grant      <= pick_m1 ? 2'b10 : 2'b01;
                  busy       <= 1'b1;
                  last_owner <= pick_m1;
               end
            end
            BUSY0, BUSY1: begin
               if (done_now) begin
                  state   <= DONE;
                  s_valid <= 1'b0;
                  grant   <= 2'b00;
                  busy    <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Count loader grants taken while the CPU is waiting; any CPU grant or dropped lock restarts it
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lock_cnt <= '0;
      else if (!m1_lock)
         lock_cnt <= '0;
      else if (state == IDLE && req_any) begin
         if (!pick_m1)
            lock_cnt <= '0;
         else if (m0_valid && lock_cnt < LOCK_LIM)
            lock_cnt <= lock_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_flash_arb.sv
// tb/tb_flash_arb.sv - randomized self-checking bench for flash_arb
module tb_flash_arb;
   localparam int ADDR_W   = 24;
   localparam int LOCK_MAX = 8;
   localparam int TIMEOUT  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              m0_valid, m0_ready, m1_valid, m1_ready, m1_lock;
   logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
   logic [31:0]       m0_rdata, m1_rdata, s_rdata;
   logic              s_valid, s_ready, busy, err, err_clr;
   logic [1:0]        grant;

   int n_checks = 0;
   int n_fail   = 0;
   int mdl_last;
   int mdl_cnt;

   flash_arb #(.ADDR_W(ADDR_W), .LOCK_MAX(LOCK_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
      .m1_lock(m1_lock),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_rdata(s_rdata),
      .grant(grant), .busy(busy), .err(err), .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int model_pick(input bit v0, input bit v1, input bit lock);
      if (v0 && !v1) return 0;
      if (v1 && !v0) return 1;
      if (lock && mdl_last == 1 && mdl_cnt < LOCK_MAX) return 1;
      return 1 - mdl_last;
   endfunction

   task automatic model_grant(input int w, input bit v0, input bit lock);
      if (!lock)       mdl_cnt = 0;
      else if (w == 0) mdl_cnt = 0;
      else if (v0)     mdl_cnt++;
      mdl_last = w;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; m0_valid = 0; m1_valid = 0; m1_lock = 0; s_ready = 0; err_clr = 0;
      #1;
      check("rst_s_valid", s_valid, 0);
      check("rst_s_addr", s_addr, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b0;
      mdl_last = 1; mdl_cnt = 0;
   endtask

   // Called at a negedge; drives one arbitration round and serves the winner downstream
   task automatic run_round(input bit v0, input bit v1, input bit lock,
                            input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                            input int dly, input bit drop, input logic [31:0] d,
                            input int exp_lat, output int won);
      int exp_w;
      int wait_n;
      logic [ADDR_W-1:0] exp_a;
      m0_valid = v0; m1_valid = v1; m0_addr = a0; m1_addr = a1; m1_lock = lock;
      exp_w = model_pick(v0, v1, lock);
      model_grant(exp_w, v0, lock);
      exp_a = exp_w ? a1 : a0;
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (!s_valid && wait_n < 8);
      check("s_valid_rise", s_valid, 1);
      if (exp_lat > 0) check("req_latency", wait_n, exp_lat);
      won = grant[1] ? 1 : (grant[0] ? 0 : -1);
      check("grant", grant, exp_w ? 2'b10 : 2'b01);
      check("s_addr", s_addr, exp_a);
      check("busy", busy, 1);
      if (drop) begin
         if (exp_w == 1) m1_valid = 0; else m0_valid = 0;
      end
      for (int i = 0; i < dly; i++) begin
         #1;
         check("ready_early", {m0_ready, m1_ready}, 0);
         @(negedge clk);
         check("s_valid_hold", s_valid, 1);
         check("s_addr_hold", s_addr, exp_a);
         check("grant_hold", grant, exp_w ? 2'b10 : 2'b01);
      end
      s_ready = 1'b1; s_rdata = d;
      #1;
      if (exp_w == 1) begin
         check("m1_ready", m1_ready, !drop);
         check("m1_rdata", m1_rdata, d);
         check("m0_ready_loser", m0_ready, 0);
         check("m0_rdata_loser", m0_rdata, 0);
      end else begin
         check("m0_ready", m0_ready, !drop);
         check("m0_rdata", m0_rdata, d);
         check("m1_ready_loser", m1_ready, 0);
         check("m1_rdata_loser", m1_rdata, 0);
      end
      @(negedge clk);
      s_ready = 1'b0;
      check("done_s_valid", s_valid, 0);
      check("done_grant", grant, 0);
      check("done_busy", busy, 0);
      if (exp_w == 1) m1_valid = 0; else m0_valid = 0;
   endtask

   initial begin
      int won;
      int exp_ord[4];
      bit pend0, pend1, v0, v1, lock;
      logic [ADDR_W-1:0] a0, a1;
      exp_ord = '{0, 1, 0, 1};
      reset = 1'b1; m0_valid = 0; m1_valid = 0; m1_lock = 0; m0_addr = 0; m1_addr = 0;
      s_ready = 0; s_rdata = 0; err_clr = 0;
      mdl_last = 1; mdl_cnt = 0;

      // single CPU fetch
      do_reset();
      run_round(1, 0, 0, 24'h100000, 24'h0, 3, 0, 32'hDEADBEEF, 1, won);
      check("single_owner", won, 0);

      // plain round-robin from reset
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_round(1, 1, 0, 24'h000100 + 24'(i), 24'h200000 + 24'(i), i, 0, $urandom, (i == 0) ? 1 : 2, won);
         check("rr_order", won, exp_ord[i]);
      end

      // loader burst lock
      do_reset();
      for (int i = 0; i < LOCK_MAX + 1; i++) begin
         run_round(1, 1, 1, 24'h000040, 24'(32'h300000 + 4 * i), 0, 0, $urandom, (i == 0) ? 1 : 2, won);
         check("lock_order", won, (i < LOCK_MAX) ? 1 : 0);
      end

      // reset mid-transaction on m1, then a normal m0 fetch
      do_reset();
      m1_valid = 1; m1_addr = 24'h0ABCDE;
      begin
         int n = 0;
         do begin @(negedge clk); n++; end while (!s_valid && n < 8);
      end
      check("rst_mid_grant_before", grant, 2'b10);
      s_ready = 1'b1; s_rdata = 32'h12345678; reset = 1'b1;
      #1;
      check("rst_mid_m1_ready", m1_ready, 0);
      check("rst_mid_s_valid", s_valid, 0);
      check("rst_mid_grant", grant, 0);
      @(negedge clk);
      reset = 1'b0; s_ready = 0; m1_valid = 0;
      mdl_last = 1; mdl_cnt = 0;
      run_round(1, 0, 0, 24'h000800, 24'h0, 1, 0, 32'hCAFEF00D, 1, won);
      check("post_rst_owner", won, 0);

`ifdef FLASH_ARB_TIMEOUT_EN
      // unresponsive controller
      do_reset();
      m0_valid = 1; m0_addr = 24'h001000;
      begin
         int n = 0;
         int seen = 0;
         do begin @(negedge clk); n++; end while (!s_valid && n < 8);
         n = 1;
         while (!m0_ready && n < 40) begin @(negedge clk); n++; end
         check("tmo_cycles", n, TIMEOUT);
         check("tmo_rdata", m0_rdata, 32'hFFFF_FFFF);
         @(negedge clk);
         m0_valid = 0;
         check("tmo_err", err, 1);
         check("tmo_s_valid", s_valid, 0);
         repeat (3) @(negedge clk);
         check("tmo_err_sticky", err, 1);
         err_clr = 1;
         @(negedge clk);
         err_clr = 0;
         check("tmo_err_clr", err, 0);
         seen = 1;
      end
      mdl_last = 0; mdl_cnt = 0;
`else
      // controller that answers late: arbiter must just wait
      do_reset();
      m0_valid = 1; m0_addr = 24'h001000;
      repeat (40) @(negedge clk);
      check("wait_s_valid", s_valid, 1);
      check("wait_err", err, 0);
      check("wait_ready", m0_ready, 0);
      s_ready = 1; s_rdata = 32'h0BADF00D;
      #1;
      check("wait_m0_ready", m0_ready, 1);
      @(negedge clk);
      s_ready = 0; m0_valid = 0;
      mdl_last = 0; mdl_cnt = 0;
`endif

      // randomized traffic: losers keep their request pending
      @(negedge clk);
      pend0 = 0; pend1 = 0; a0 = 0; a1 = 0;
      for (int r = 0; r < 60; r++) begin
         v0 = pend0 | ($urandom_range(0, 1) == 1);
         v1 = pend1 | ($urandom_range(0, 1) == 1);
         if (!v0 && !v1) v1 = 1;
         if (!pend0) a0 = ADDR_W'($urandom);
         if (!pend1) a1 = ADDR_W'($urandom);
         lock = ($urandom_range(0, 3) != 0);
         run_round(v0, v1, lock, a0, a1, $urandom_range(0, 4), ($urandom_range(0, 5) == 0),
                   $urandom, (r == 0) ? 0 : 2, won);
         pend0 = v0 && (won != 0);
         pend1 = v1 && (won != 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/flash_arb.md
FLASH_ARB -- requirements
Module: flash_arb

Interface
REQ-001 Parameter ADDR_W, default 24, flash byte-address width for all address ports.
REQ-002 Parameter LOCK_MAX, default 8, maximum consecutive m1 transactions while m0 waits.
REQ-003 Parameter TIMEOUT, default 1023, downstream response limit in clk cycles (range 1..65535).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 m0_valid / m0_ready  in/out  1/1  CPU instruction-fetch request and completion.
REQ-007 m0_addr / m0_rdata  in/out  ADDR_W/32  CPU fetch address and returned data.
REQ-008 m1_valid / m1_ready  in/out  1/1  boot-loader request and completion.
REQ-009 m1_addr / m1_rdata  in/out  ADDR_W/32  loader address and returned data.
REQ-010 m1_lock  in  1  loader burst hint: keep grant on m1 between its transactions.
REQ-011 s_valid / s_ready  out/in  1/1  request to QSPI memory controller and its completion.
REQ-012 s_addr / s_rdata  out/in  ADDR_W/32  downstream address and data.
REQ-013 grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.
REQ-014 busy  out  1  transaction in flight.
REQ-015 err / err_clr  out/in  1/1  sticky timeout flag and its synchronous clear.

Function
REQ-016 FSM states: IDLE, BUSY0, BUSY1, DONE. Exactly one state at all times.
REQ-017 IDLE -> BUSYx when a valid request exists: capture owner and address into registers; s_valid asserts the next cycle (1-cycle request latency).
REQ-018 Arbitration in IDLE: one requester valid -> grant it. Both valid -> round-robin against last_owner.
REQ-019 Exception to REQ-018: m1_lock high, last_owner = m1, and lock_cnt < LOCK_MAX -> grant m1.
REQ-020 lock_cnt behaviour:
- increments on each m1 grant made while m0_valid is high;
- clears on any m0 grant;
- clears when m1_lock is low.
REQ-021 BUSYx: s_valid = 1 and s_addr = captured address, both stable until s_ready.
REQ-022 Completion: mx_ready = s_ready & mx_valid & (owner = x), combinational. mx_rdata = s_rdata when owner = x, else 0.
REQ-023 Completion moves the FSM BUSYx -> DONE. DONE lasts exactly one cycle (s_valid low), then IDLE. Minimum spacing between downstream requests is 2 idle cycles.
REQ-024 Requester dropping valid mid-transaction:
- downstream transaction still completes;
- no ready pulse goes to that requester;
- FSM proceeds normally.
REQ-025 Address/valid changes on the non-owner are ignored while busy. That request waits and is arbitrated in the next IDLE.
REQ-026 busy = 1 in BUSY0/BUSY1 only. grant = 01 in BUSY0, 10 in BUSY1, 00 otherwise.
REQ-027 err_clr clears err. A timeout in the same cycle as err_clr wins (err stays 1).

Reset
REQ-028 Reset (async assert, sync deassert handled outside) drives these values:
- state = IDLE;
- s_valid = 0, s_addr = 0;
- grant = 00, busy = 0, err = 0;
- last_owner = m1, so m0 wins the first tie;
- lock_cnt = 0, timer = 0.
REQ-029 Reset mid-transaction abandons it immediately. No ready pulse is emitted.

Configuration
REQ-030 Macro FLASH_ARB_TIMEOUT_EN defined:
- timer counts BUSYx cycles without s_ready;
- on reaching TIMEOUT: pulse owner's mx_ready with rdata = 32'hFFFF_FFFF, set err, drop s_valid, go to DONE.
REQ-031 FLASH_ARB_TIMEOUT_EN undefined: no timer logic, err tied 0, BUSYx waits for s_ready indefinitely.

Verification
REQ-032 Single m0 fetch, addr 0x100000, s_ready 3 cycles after s_valid, s_rdata 0xDEADBEEF -> m0_ready one cycle, m0_rdata 0xDEADBEEF, grant 01 throughout.
REQ-033 m0 and m1 valid together from reset, 4 transactions -> grant order m0, m1, m0, m1.
REQ-034 m1_lock high, m1 continuously valid, m0 valid, LOCK_MAX = 8 -> 8 consecutive m1 grants, then one m0 grant.
REQ-035 With FLASH_ARB_TIMEOUT_EN, TIMEOUT = 16, s_ready never asserted -> m0_ready pulse after 16 busy cycles, rdata 0xFFFFFFFF, err = 1 until err_clr.
REQ-036 reset asserted in BUSY1 -> next cycle s_valid = 0, grant = 00, no m1_ready; a subsequent m0 request is served normally.
